// File: rtl/isram_arb.sv
// Arbiter for the shared single-ported instruction SRAM: fetch vs load/store,
// with one-cycle read-return steering and a held fetch doubleword for decode.
module isram_arb #(
    parameter int unsigned MAX_LR_RUN = 4
) (
    input  logic        clk,
    input  logic        cpurst_n,
    input  logic        fet_req,
    input  logic [31:3] fet_adr,
    input  logic        fet_flush,
    input  logic        lr_req,
    input  logic        lr_we,
    input  logic [31:3] lr_adr,
    input  logic [63:0] lr_wdata,
    input  logic [7:0]  lr_wmask,
    input  logic [63:0] sram_rdata,
    output logic        sram_cs,
    output logic        sram_we,
    output logic [31:3] sram_adr,
    output logic [63:0] sram_wdata,
    output logic [7:0]  sram_wmask,
    output logic        fet_gnt,
    output logic        fet_stall,
    output logic [63:0] fet_instr,
    output logic        fet_instr_vld,
    output logic        lr_ack,
    output logic [63:0] lr_rdata,
    output logic        lr_rdata_vld
);

    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_FET  = 2'd1,
        RET_LR   = 2'd2
    } ret_e;

    localparam logic [3:0] MAX_RUN_C = 4'(MAX_LR_RUN);

    ret_e        ret_q, ret_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic [63:0] instr_hold_q, instr_hold_d;
    logic [63:0] lr_hold_q, lr_hold_d;
    logic        flush_q;
    logic        lr_win_s, fet_win_s;

    // Arbitration: lr wins unless fetch has waited MAX_LR_RUN lr grants
    always_comb begin
        lr_win_s  = 1'b0;
        fet_win_s = 1'b0;
        if (lr_req && (!fet_req || (run_cnt_q < MAX_RUN_C))) begin
            lr_win_s = 1'b1;
        end else if (fet_req) begin
            fet_win_s = 1'b1;
        end else begin
            lr_win_s  = 1'b0;
            fet_win_s = 1'b0;
        end
    end

    assign fet_gnt   = fet_win_s;
    assign lr_ack    = lr_win_s;
    assign fet_stall = fet_req & ~fet_win_s;

    // SRAM port drive follows the winner; idle port is driven all-zero
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_adr   = 29'd0;
        sram_wdata = 64'd0;
        sram_wmask = 8'd0;
        if (lr_win_s) begin
            sram_cs    = 1'b1;
            sram_we    = lr_we;
            sram_adr   = lr_adr;
            sram_wdata = lr_wdata;
            sram_wmask = lr_wmask;
        end else if (fet_win_s) begin
            sram_cs  = 1'b1;
            sram_adr = fet_adr;
        end else begin
            sram_cs = 1'b0;
        end
    end

    // Starvation counter: counts lr grants that made a requesting fetch wait
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (!fet_req || fet_win_s) begin
            run_cnt_d = 4'd0;
        end else if (lr_win_s && (run_cnt_q < MAX_RUN_C)) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end else begin
            run_cnt_d = run_cnt_q;
        end
    end

    // Return-owner state register
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            ret_q <= RET_NONE;
        end else begin
            ret_q <= ret_d;
        end
    end

    // Return-owner next state: who gets the read data next cycle
    always_comb begin
        ret_d = RET_NONE;
        if (fet_win_s) begin
            ret_d = RET_FET;
        end else if (lr_win_s && !lr_we) begin
            ret_d = RET_LR;
        end else begin
            ret_d = RET_NONE;
        end
    end

    // Return steering; hold registers keep the last data when not returning
    always_comb begin
        fet_instr     = instr_hold_q;
        fet_instr_vld = 1'b0;
        lr_rdata      = lr_hold_q;
        lr_rdata_vld  = 1'b0;
        instr_hold_d  = instr_hold_q;
        lr_hold_d     = lr_hold_q;
        case (ret_q)
            RET_FET: begin
                fet_instr     = sram_rdata;
                fet_instr_vld = ~flush_q;
                instr_hold_d  = sram_rdata;
            end
            RET_LR: begin
                lr_rdata     = sram_rdata;
                lr_rdata_vld = 1'b1;
                lr_hold_d    = sram_rdata;
            end
            RET_NONE: begin
                fet_instr_vld = 1'b0;
                lr_rdata_vld  = 1'b0;
            end
            default: begin
                fet_instr_vld = 1'b0;
                lr_rdata_vld  = 1'b0;
            end
        endcase
    end

    // Datapath and counter registers
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            run_cnt_q    <= 4'd0;
            instr_hold_q <= 64'd0;
            lr_hold_q    <= 64'd0;
            flush_q      <= 1'b0;
        end else begin
            run_cnt_q    <= run_cnt_d;
            instr_hold_q <= instr_hold_d;
            lr_hold_q    <= lr_hold_d;
            flush_q      <= fet_flush;
        end
    end

    isram_arb_chk #(.MAX_LR_RUN(MAX_LR_RUN)) u_chk (
        .clk      (clk),
        .cpurst_n (cpurst_n),
        .fet_gnt  (fet_gnt),
        .lr_ack   (lr_ack)
    );

endmodule

// Invariant checks for isram_arb: legal parameter and exclusive grants.
module isram_arb_chk #(
    parameter int unsigned MAX_LR_RUN = 4
) (
    input logic clk,
    input logic cpurst_n,
    input logic fet_gnt,
    input logic lr_ack
);

    if ((MAX_LR_RUN == 0) || (MAX_LR_RUN > 15)) begin : g_bad_max_run
        $error("isram_arb: MAX_LR_RUN must be in 1..15");
    end

    a_one_grant: assert property (@(posedge clk) disable iff (!cpurst_n) !(fet_gnt && lr_ack));

endmodule

// File: tb/tb_isram_arb.sv
module tb_isram_arb;

    logic        clk = 1'b0;
    logic        cpurst_n;
    logic        fet_req, fet_flush, lr_req, lr_we;
    logic [31:3] fet_adr, lr_adr;
    logic [63:0] lr_wdata, sram_rdata;
    logic [7:0]  lr_wmask;
    logic        sram_cs, sram_we, fet_gnt, fet_stall, fet_instr_vld, lr_ack, lr_rdata_vld;
    logic [31:3] sram_adr;
    logic [63:0] sram_wdata, fet_instr, lr_rdata;
    logic [7:0]  sram_wmask;

    always #5 clk = ~clk;

    isram_arb #(.MAX_LR_RUN(4)) dut (
        .clk(clk), .cpurst_n(cpurst_n),
        .fet_req(fet_req), .fet_adr(fet_adr), .fet_flush(fet_flush),
        .lr_req(lr_req), .lr_we(lr_we), .lr_adr(lr_adr),
        .lr_wdata(lr_wdata), .lr_wmask(lr_wmask), .sram_rdata(sram_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_adr(sram_adr),
        .sram_wdata(sram_wdata), .sram_wmask(sram_wmask),
        .fet_gnt(fet_gnt), .fet_stall(fet_stall),
        .fet_instr(fet_instr), .fet_instr_vld(fet_instr_vld),
        .lr_ack(lr_ack), .lr_rdata(lr_rdata), .lr_rdata_vld(lr_rdata_vld)
    );

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } ret_t;

    ret_t fet_q[$];
    ret_t lr_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    localparam logic [63:0] DA = 64'hA0A0_0000_0000_000A;
    localparam logic [63:0] DB = 64'hB0B0_0000_0000_000B;
    localparam logic [63:0] DC = 64'hC0C0_0000_0000_000C;
    localparam logic [63:0] DD = 64'hD0D0_0000_0000_000D;
    localparam logic [63:0] DE = 64'hE0E0_0000_0000_000E;
    localparam logic [63:0] DG = 64'h6060_1234_5678_9ABC;
    localparam logic [63:0] DH = 64'h7070_0000_0000_0077;
    localparam logic [63:0] DJ = 64'h9090_0000_0000_0099;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: returns must appear exactly in their expected cycle
    always @(negedge clk) begin
        if (fet_q.size() > 0 && fet_q[0].cyc == cyc) begin
            chk("fet_instr_vld", 64'(fet_instr_vld), 64'd1);
            chk("fet_instr", fet_instr, fet_q[0].data);
            void'(fet_q.pop_front());
        end else if (fet_instr_vld) begin
            chk("fet_instr_vld_unexpected", 64'(fet_instr_vld), 64'd0);
        end
        if (lr_q.size() > 0 && lr_q[0].cyc == cyc) begin
            chk("lr_rdata_vld", 64'(lr_rdata_vld), 64'd1);
            chk("lr_rdata", lr_rdata, lr_q[0].data);
            void'(lr_q.pop_front());
        end else if (lr_rdata_vld) begin
            chk("lr_rdata_vld_unexpected", 64'(lr_rdata_vld), 64'd0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        fet_req = 1'b0; fet_flush = 1'b0; lr_req = 1'b0; lr_we = 1'b0;
    endtask

    task automatic push_fet(input logic [63:0] d);
        ret_t r;
        r.cyc = cyc + 1; r.data = d;
        fet_q.push_back(r);
    endtask

    task automatic push_lr(input logic [63:0] d);
        ret_t r;
        r.cyc = cyc + 1; r.data = d;
        lr_q.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] fadr [3];
        logic [63:0] fdat [4];
        fadr[0] = 30'h10; fadr[1] = 30'h11; fadr[2] = 30'h12;
        fdat[0] = 64'd0; fdat[1] = DA; fdat[2] = DB; fdat[3] = DC;

        cpurst_n = 1'b1;
        idle();
        fet_adr = 29'd0; lr_adr = 29'd0; lr_wdata = 64'd0; lr_wmask = 8'd0; sram_rdata = 64'd0;
        #1 cpurst_n = 1'b0;
        #2;
        chk("rst_fet_instr", fet_instr, 64'd0);
        chk("rst_fet_vld", 64'(fet_instr_vld), 64'd0);
        chk("rst_lr_vld", 64'(lr_rdata_vld), 64'd0);
        chk("rst_lr_rdata", lr_rdata, 64'd0);
        fet_req = 1'b1; fet_adr = 29'h7;
        #1;
        chk("rst_comb_cs", 64'(sram_cs), 64'd1);
        chk("rst_comb_gnt", 64'(fet_gnt), 64'd1);
        chk("rst_comb_adr", 64'(sram_adr), 64'h7);
        idle();
        next_cycle();
        next_cycle();
        cpurst_n = 1'b1;
        next_cycle();

        // Fetch-only stream
        for (int i = 0; i < 4; i++) begin
            sram_rdata = fdat[i];
            if (i < 3) begin
                fet_req = 1'b1; fet_adr = fadr[i][28:0];
                push_fet(fdat[i + 1]);
            end else begin
                idle();
            end
            @(negedge clk);
            chk("t1_stall", 64'(fet_stall), 64'd0);
            chk("t1_cs", 64'(sram_cs), (i < 3) ? 64'd1 : 64'd0);
            chk("t1_adr", 64'(sram_adr), (i < 3) ? 64'(fadr[i]) : 64'd0);
            chk("t1_we", 64'(sram_we), 64'd0);
            next_cycle();
        end
        sram_rdata = 64'd0;
        @(negedge clk);
        chk("t1_hold", fet_instr, DC);
        chk("t1_hold_vld", 64'(fet_instr_vld), 64'd0);
        next_cycle();

        // lr read preempts a waiting fetch
        fet_req = 1'b1; fet_adr = 29'h20;
        push_fet(DE);
        next_cycle();
        sram_rdata = DE;
        lr_req = 1'b1; lr_we = 1'b0; lr_adr = 29'h40;
        push_lr(DD);
        @(negedge clk);
        chk("t2_ack", 64'(lr_ack), 64'd1);
        chk("t2_stall", 64'(fet_stall), 64'd1);
        chk("t2_fet_gnt", 64'(fet_gnt), 64'd0);
        chk("t2_adr", 64'(sram_adr), 64'h40);
        next_cycle();
        idle();
        sram_rdata = DD;
        @(negedge clk);
        chk("t2_fet_held", fet_instr, DE);
        chk("t2_fet_vld", 64'(fet_instr_vld), 64'd0);
        next_cycle();

        // Starvation bound: lr,lr,lr,lr,fet repeating
        fet_req = 1'b1; fet_adr = 29'h50;
        lr_req = 1'b1; lr_we = 1'b1; lr_adr = 29'h60; lr_wdata = 64'h5555; lr_wmask = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            sram_rdata = 64'hF000 + 64'(i);
            if (i % 5 == 4) push_fet(64'hF000 + 64'(i + 1));
            @(negedge clk);
            chk("t3_fet_gnt", 64'(fet_gnt), (i % 5 == 4) ? 64'd1 : 64'd0);
            chk("t3_lr_ack", 64'(lr_ack), (i % 5 == 4) ? 64'd0 : 64'd1);
            if (i == 4) chk("t3_run_sat", 64'(dut.run_cnt_q), 64'd4);
            if (i == 5) chk("t3_run_clr", 64'(dut.run_cnt_q), 64'd0);
            next_cycle();
        end
        idle();
        sram_rdata = 64'hF000 + 64'd10;
        next_cycle();

        // lr write
        lr_req = 1'b1; lr_we = 1'b1; lr_adr = 29'h55;
        lr_wdata = 64'h1122334455667788; lr_wmask = 8'h0F;
        @(negedge clk);
        chk("t4_ack", 64'(lr_ack), 64'd1);
        chk("t4_we", 64'(sram_we), 64'd1);
        chk("t4_wmask", 64'(sram_wmask), 64'h0F);
        chk("t4_wdata", sram_wdata, 64'h1122334455667788);
        next_cycle();
        idle();
        @(negedge clk);
        chk("t4_lr_vld", 64'(lr_rdata_vld), 64'd0);
        chk("t4_lr_rdata_held", lr_rdata, DD);
        next_cycle();

        // Flush kills the return but the hold register still loads
        fet_req = 1'b1; fet_flush = 1'b1; fet_adr = 29'h30;
        @(negedge clk);
        chk("t5_gnt", 64'(fet_gnt), 64'd1);
        next_cycle();
        idle();
        sram_rdata = DG;
        @(negedge clk);
        chk("t5_vld", 64'(fet_instr_vld), 64'd0);
        chk("t5_instr", fet_instr, DG);
        next_cycle();
        sram_rdata = 64'd0;
        @(negedge clk);
        chk("t5_hold", fet_instr, DG);
        chk("t5_hold_reg", dut.instr_hold_q, DG);
        next_cycle();

        // Async reset while a fetch return is pending
        fet_req = 1'b1; fet_adr = 29'h31;
        next_cycle();
        idle();
        sram_rdata = DH;
        #1 cpurst_n = 1'b0;
        #1;
        chk("t6_rst_instr", fet_instr, 64'd0);
        chk("t6_rst_vld", 64'(fet_instr_vld), 64'd0);
        next_cycle();
        cpurst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_post_vld", 64'(fet_instr_vld), 64'd0);
            chk("t6_post_instr", fet_instr, 64'd0);
            next_cycle();
        end
        fet_req = 1'b1; fet_adr = 29'h32;
        push_fet(DJ);
        next_cycle();
        idle();
        sram_rdata = DJ;
        next_cycle();
        next_cycle();

        chk("fet_queue_empty", 64'(fet_q.size()), 64'd0);
        chk("lr_queue_empty", 64'(lr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/isram_arb.md
# isram_arb

Arbiter and sequencer for the single-ported 64-bit instruction SRAM, shared between the fetch unit and the load/store path. Load/store accesses to instruction space are one such access path. It sits between the fetch stage and the ISRAM macro, and grants one requester per cycle. It steers the one-cycle-latency read data back to its owner. It also holds the last fetched doubleword so decode sees stable instruction bits while fetch is locked out. A starvation counter bounds how long load/store traffic can block fetch.

## Interface
- MAX_LR_RUN, 4, maximum consecutive load/store grants while fetch is waiting (1..15).
- clk  in  1  core clock; all state on rising edge.
- cpurst_n  in  1  asynchronous active-low reset.
- fet_req  in  1  fetch wants a doubleword this cycle.
- fet_adr  in  [31:3]  fetch doubleword address.
- fet_flush  in  1  fetch redirect; discards the fetch return due next cycle.
- lr_req  in  1  load/store request; held until lr_ack.
- lr_we  in  1  1 = write, 0 = read.
- lr_adr  in  [31:3]  load/store doubleword address.
- lr_wdata  in  64  write data.
- lr_wmask  in  8  byte write enables.
- sram_rdata  in  64  SRAM read data, valid the cycle after a read select.
- sram_cs  out  1  SRAM select (combinational).
- sram_we  out  1  SRAM write enable.
- sram_adr  out  [31:3]  SRAM address.
- sram_wdata  out  64  SRAM write data.
- sram_wmask  out  8  SRAM byte mask.
- fet_gnt  out  1  fetch owns the SRAM this cycle.
- fet_stall  out  1  fet_req & !fet_gnt.
- fet_instr  out  64  fetch return data, or held doubleword.
- fet_instr_vld  out  1  fet_instr is fresh this cycle.
- lr_ack  out  1  load/store request accepted this cycle.
- lr_rdata  out  64  load return data.
- lr_rdata_vld  out  1  lr_rdata valid.

## Operation
- Grant rule, evaluated each cycle:
  - lr wins if lr_req and (!fet_req or run_cnt < MAX_LR_RUN).
  - Otherwise fetch wins if fet_req.
  - Otherwise the port is idle: sram_cs=0, and sram_adr/sram_wdata/sram_wmask/sram_we are driven 0.
- SRAM drive follows the winner:
  - Fetch grant: sram_we=0, sram_wmask=0, sram_adr=fet_adr.
  - lr grant: sram_we=lr_we, sram_adr=lr_adr, sram_wdata=lr_wdata, sram_wmask=lr_wmask.
- run_cnt (4 bits) controls starvation:
  - Increments on an lr grant while fet_req=1, saturating at MAX_LR_RUN.
  - Clears on a fetch grant or whenever fet_req=0.
  - When run_cnt==MAX_LR_RUN and fet_req=1, fetch is guaranteed the next grant.
- lr_ack=1 in the grant cycle. The requester then drops lr_req or presents a new request.
- Return owner FSM, registered, with states RET_NONE, RET_FET and RET_LR:
  - Next state is RET_FET on a fetch grant.
  - Next state is RET_LR on an lr read grant.
  - Next state is RET_NONE on an lr write or an idle cycle.
- In RET_FET:
  - fet_instr=sram_rdata.
  - fet_instr_vld=!flush_ff, where flush_ff is fet_flush registered.
  - instr_hold<=sram_rdata.
- In RET_LR: lr_rdata_vld=1, lr_rdata=sram_rdata.
- In every other state:
  - fet_instr=instr_hold and fet_instr_vld=0.
  - lr_rdata holds its last value and lr_rdata_vld=0.
- fet_flush kills only the return of a grant made in the same cycle. The hold register still updates.

## Timing
- Grant and SRAM outputs are combinational from the requests: 0-cycle arbitration.
- Read return latency is exactly 1 cycle after the grant for both requesters.
- Back-to-back grants are allowed every cycle with no bubble. Fetch→lr→fetch uses three consecutive cycles.
- Reset, asynchronous on cpurst_n low:
  - FSM=RET_NONE, run_cnt=0, instr_hold=0, lr_rdata=0, flush_ff=0.
  - Therefore fet_instr=0 and fet_instr_vld=lr_rdata_vld=0.
  - Combinational outputs still follow their inputs during reset.
- Reset asserted mid-read: the pending return is dropped, and no vld is produced after release.
- Simultaneous fet_req and lr_req with run_cnt=0: lr wins.
- MAX_LR_RUN must be at least 1 and fit in 4 bits; this is checked by a simulation assertion.

## Test plan
- Fetch only: fet_req=1 with fet_adr=0x10,0x11,0x12 on consecutive cycles, sram_rdata=A,B,C → fet_instr_vld=1 for 3 consecutive cycles starting one cycle after the first grant, with fet_instr=A,B,C; fet_stall=0 throughout.
- lr read preempts fetch:
  - Stimulus: fet_req=1, then lr_req=1, lr_we=0, lr_adr=0x40 for one cycle, with sram_rdata=D in the following cycle.
  - Response: lr_ack=1 and fet_stall=1 in that cycle; lr_rdata_vld=1 with lr_rdata=D the next cycle, where fet_instr keeps the previous held value and fet_instr_vld=0.
- Starvation with MAX_LR_RUN=4: lr_req=1 and fet_req=1 held continuously → grant pattern lr,lr,lr,lr,fet repeating, and run_cnt returns to 0 after each fetch grant.
- lr write: lr_we=1, lr_wmask=0x0F, lr_wdata=0x1122334455667788 → sram_we=1 and sram_wmask=0x0F in the same cycle; lr_rdata_vld stays 0 the next cycle.
- Flush: a fetch grant with fet_flush=1 → the next cycle has fet_instr_vld=0, while fet_instr and instr_hold equal sram_rdata.
- Async reset during a pending fetch return: assert cpurst_n=0 between clock edges → fet_instr=0 and fet_instr_vld=0 immediately; no vld appears after release until a new grant.
